pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined carry-chain adder/subtractor with a valid/ready handshake. It is the clocked successor of the combinational 32-bit ripple-carry adder. The carry chain is split into STAGES equal slices with a register boundary after each slice, so wide operands close timing at datapath clock rates. Downstream backpressure stalls the whole pipeline without losing data.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline slices and register stages; 1 ≤ STAGES ≤ WIDTH; WIDTH % STAGES == 0. Elaboration fails otherwise.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a−b, computed as a+~b+1, with cin ignored.
- in_valid  in  1  operands present this cycle.
- in_ready  out  WIDTH-independent 1  block accepts operands this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- out_valid  out  1  sum/cout/ovf hold a valid result.
- out_ready  in  1  consumer accepts the result this cycle.

## Operation
- Slice width: W = WIDTH/STAGES. Stage k (0-based) adds bits [k·W +: W] of a and b′, where b′ = sub ? ~b : b.
  - Stage 0 uses carry-in c0 = sub ? 1 : cin.
  - Stage k>0 uses the registered carry from stage k−1.
- Skew registers:
  - Operand slices not yet consumed travel alongside the pipeline.
  - Completed sum slices are carried forward until the final stage.
  - sum is fully aligned: every bit of sum belongs to the same transaction.
- Each stage holds a valid bit. Pipeline advance is global: advance = !out_valid || out_ready.
- in_ready = advance, combinational.
  - A transfer occurs when in_valid && in_ready.
  - When advance=1, stage 0 loads in_valid; when advance=0, every stage holds.
- Bubbles do not collapse: an empty stage behind a stalled output waits as well.
- Stage STAGES−1 drives sum, cout, ovf and out_valid directly from its registers.
- ovf is computed from the MSB slice's internal carry into bit WIDTH−1 and its carry out. It is registered with the final stage.
- When out_valid=0, sum/cout/ovf retain their last values. Their contents are don't-care for checking but must not be X after reset.
- The datapath is modulo 2^WIDTH. Wrap-around is reported only via cout and ovf; there is no saturation.

## Timing
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1 when there is no stall.
- Throughput: one transaction per cycle while out_ready=1.
- Reset (asynchronous assert, synchronous-edge release):
  - All valid bits clear; sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready reads 1 during and after reset, because out_valid=0. Transfers attempted while rst=1 are discarded.
- Reset mid-operation: all in-flight transactions are dropped. No result appears after release unless new operands are accepted.
- Stall: with out_valid=1 and out_ready=0, in_ready=0 and outputs are held bit-stable until the handshake.
- Simultaneous output handshake and input transfer in the same cycle:
  - The pipeline advances.
  - The new result (or a bubble) appears on the next edge.
  - No transaction is duplicated or lost.
- sub and cin are sampled with a and b at the transfer edge and are carried per-transaction. Mixed add/sub streams are legal back-to-back.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1. Stream four transfers with sub=0:
  - 00000001+00000002, cin=0 → sum=00000003, cout=0, ovf=0.
  - FFFFFFFF+00000001, cin=0 → sum=00000000, cout=1, ovf=0.
  - AAAAAAAA+55555555, cin=0 → sum=FFFFFFFF, cout=0.
  - 12345678+87654321, cin=1 → sum=9999999A, cout=0.
  - Results appear on consecutive cycles, first result 4 cycles after the first transfer.
- Subtract/overflow:
  - 00000005−00000007, sub=1, cin=1 (ignored) → FFFFFFFE, cout=0, ovf=0.
  - 7FFFFFFF+00000001 → 80000000, ovf=1, cout=0.
  - 80000000−00000001 → 7FFFFFFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - in_ready=0 while out_valid=1.
  - The held sum stays constant.
  - After out_ready returns to 1, all accepted results emerge in order with no loss or duplication.
- Carry crossing every slice boundary: 0000FFFF+00000001 and 00FFFFFF+00000001, STAGES=4.
  - Sums are 00010000 and 01000000.
  - Verifies registered inter-slice carries.
- Reset mid-flight: accept 3 transactions, assert rst for 1 cycle, release.
  - out_valid stays 0 until a new transaction is accepted.
  - Its result arrives STAGES cycles later.
- Parameter sweep: (WIDTH, STAGES) ∈ {(8,1), (8,8), (64,4)} with 1000 random operands, random in_valid/out_ready.
  - Each result must equal a reference model of {cout, sum} = a + b′ + c0.
  - ovf must match the signed check.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The slave side is the adder; the master side is the producer/consumer.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, ovf, out_valid
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined carry-chain adder/subtractor: STAGES slices of WIDTH/STAGES bits with a
// register boundary after each slice; the whole pipe stalls together under backpressure.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave bus
);
  localparam int S_SAFE = (STAGES > 0) ? STAGES : 1;
  localparam int W      = WIDTH / S_SAFE;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % S_SAFE) != 0) begin : g_bad_params
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic advance_s;

  assign advance_s    = ~g_stage[STAGES-1].vld_q | bus.out_ready;
  assign bus.in_ready = advance_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // REM: operand bits still unconsumed on entry to this stage, current slice at the LSBs.
    localparam int REM = WIDTH - k * W;

    logic               vld_in_s;
    logic               c_in_s;
    logic [REM-1:0]     a_in_s;
    logic [REM-1:0]     b_in_s;
    logic [(k+1)*W-1:0] s_new_s;
    logic [W-1:0]       slice_s;
    logic               cout_s;
    logic               vld_d;
    logic               vld_q;
    logic               c_d;
    logic               c_q;
    logic [(k+1)*W-1:0] s_d;
    logic [(k+1)*W-1:0] s_q;

    if (k == 0) begin : g_src
      assign vld_in_s = bus.in_valid;
      assign c_in_s   = bus.sub ? 1'b1 : bus.cin;
      assign a_in_s   = bus.a;
      assign b_in_s   = bus.sub ? ~bus.b : bus.b;
      assign s_new_s  = slice_s;
    end else begin : g_src
      assign vld_in_s = g_stage[k-1].vld_q;
      assign c_in_s   = g_stage[k-1].c_q;
      assign a_in_s   = g_stage[k-1].g_fwd.a_q;
      assign b_in_s   = g_stage[k-1].g_fwd.b_q;
      assign s_new_s  = {slice_s, g_stage[k-1].s_q};
    end

    assign {cout_s, slice_s} = {1'b0, a_in_s[W-1:0]} + {1'b0, b_in_s[W-1:0]}
                               + {{W{1'b0}}, c_in_s};

    // Stage next state: load from predecessor on a global advance, otherwise hold.
    always_comb begin
      if (advance_s) begin
        vld_d = vld_in_s;
        c_d   = cout_s;
        s_d   = s_new_s;
      end else begin
        vld_d = vld_q;
        c_d   = c_q;
        s_d   = s_q;
      end
    end

    // Stage valid, slice carry and accumulated sum registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= {((k+1)*W){1'b0}};
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        s_q   <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-W-1:0] a_d;
      logic [REM-W-1:0] a_q;
      logic [REM-W-1:0] b_d;
      logic [REM-W-1:0] b_q;

      // Skew next state: operand slices not yet added ride along with their transaction.
      always_comb begin
        if (advance_s) begin
          a_d = a_in_s[REM-1:W];
          b_d = b_in_s[REM-1:W];
        end else begin
          a_d = a_q;
          b_d = b_q;
        end
      end

      // Operand skew registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= {(REM-W){1'b0}};
          b_q <= {(REM-W){1'b0}};
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB equals a^b^sum at that bit, so no separate tap is needed.
      always_comb begin
        if (advance_s) begin
          ovf_d = a_in_s[W-1] ^ b_in_s[W-1] ^ slice_s[W-1] ^ cout_s;
        end else begin
          ovf_d = ovf_q;
        end
      end

      // Signed-overflow register, aligned with the final sum slice.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
  assign bus.out_valid = g_stage[STAGES-1].vld_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed scenarios on a 32/4 instance, then random traffic on
// (32,4), (8,1), (8,8) and (64,4) instances against an arithmetic reference model.
module tb_pipelined_adder;
  localparam int N = 4;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus0 ();
  pipelined_adder_if #(.WIDTH(8))  bus1 ();
  pipelined_adder_if #(.WIDTH(8))  bus2 ();
  pipelined_adder_if #(.WIDTH(64)) bus3 ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  pipelined_adder #(.WIDTH(8),  .STAGES(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  logic [63:0] a_v [N];
  logic [63:0] b_v [N];
  logic        cin_v [N];
  logic        sub_v [N];
  logic        iv_v [N];
  logic        or_v [N];
  logic [63:0] sum_o [N];
  logic [63:0] prev_sum [N];
  logic        co_o [N];
  logic        ov_o [N];
  logic        vo_o [N];
  logic        ir_o [N];
  logic        prev_stall [N];
  exp_t        sb [N][32];
  int          acc_cyc [N][32];
  int          wp [N];
  int          rp [N];
  int          acc_cnt [N];
  int          cyc;
  int          errors;
  int          checks;
  logic        lat_on;
  logic        have_lit;
  exp_t        lit;

  function automatic int wid(input int i);
    case (i)
      0:       return 32;
      1:       return 8;
      2:       return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int stg(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] mask64(input int w);
    if (w >= 64) return {64{1'b1}};
    else return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain unsigned and signed arithmetic on the operand values.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [67:0] pw, ua, ub, u;
    logic signed [67:0] sa, sbv, t, lim;
    pw  = 68'd1 << w;
    ua  = {4'd0, a};
    ub  = {4'd0, b};
    sa  = a[w-1] ? $signed(ua - pw) : $signed(ua);
    sbv = b[w-1] ? $signed(ub - pw) : $signed(ub);
    lim = $signed(pw >> 1);
    if (sub) begin
      u    = ua - ub;
      e.co = (ua >= ub);
      t    = sa - sbv;
    end else begin
      u    = ua + ub + {67'd0, cin};
      e.co = (u >= pw);
      t    = sa + sbv + $signed({67'd0, cin});
    end
    e.s  = u[63:0] & mask64(w);
    e.ov = (t >= lim) || (t < -lim);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    bus0.a = a_v[0][31:0]; bus0.b = b_v[0][31:0]; bus0.cin = cin_v[0]; bus0.sub = sub_v[0];
    bus0.in_valid = iv_v[0]; bus0.out_ready = or_v[0];
    bus1.a = a_v[1][7:0]; bus1.b = b_v[1][7:0]; bus1.cin = cin_v[1]; bus1.sub = sub_v[1];
    bus1.in_valid = iv_v[1]; bus1.out_ready = or_v[1];
    bus2.a = a_v[2][7:0]; bus2.b = b_v[2][7:0]; bus2.cin = cin_v[2]; bus2.sub = sub_v[2];
    bus2.in_valid = iv_v[2]; bus2.out_ready = or_v[2];
    bus3.a = a_v[3]; bus3.b = b_v[3]; bus3.cin = cin_v[3]; bus3.sub = sub_v[3];
    bus3.in_valid = iv_v[3]; bus3.out_ready = or_v[3];
  endtask

  task automatic observe();
    sum_o[0] = {32'd0, bus0.sum}; co_o[0] = bus0.cout; ov_o[0] = bus0.ovf;
    vo_o[0] = bus0.out_valid; ir_o[0] = bus0.in_ready;
    sum_o[1] = {56'd0, bus1.sum}; co_o[1] = bus1.cout; ov_o[1] = bus1.ovf;
    vo_o[1] = bus1.out_valid; ir_o[1] = bus1.in_ready;
    sum_o[2] = {56'd0, bus2.sum}; co_o[2] = bus2.cout; ov_o[2] = bus2.ovf;
    vo_o[2] = bus2.out_valid; ir_o[2] = bus2.in_ready;
    sum_o[3] = bus3.sum; co_o[3] = bus3.cout; ov_o[3] = bus3.ovf;
    vo_o[3] = bus3.out_valid; ir_o[3] = bus3.in_ready;
  endtask

  // One clock: drive at negedge, sample 1 ns later, score the handshakes of the coming edge.
  task automatic cycle();
    exp_t e;
    apply();
    #1;
    observe();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d_in_ready", i), {63'd0, ir_o[i]}, {63'd0, (!vo_o[i] || or_v[i])});
      if (!rst) begin
        if (prev_stall[i]) begin
          chk($sformatf("u%0d_held_sum", i), sum_o[i], prev_sum[i]);
          chk($sformatf("u%0d_held_valid", i), {63'd0, vo_o[i]}, 64'd1);
        end
        if (vo_o[i] && or_v[i]) begin
          chk($sformatf("u%0d_result_expected", i), {63'd0, (rp[i] != wp[i])}, 64'd1);
          if (rp[i] != wp[i]) begin
            e = sb[i][rp[i] % 32];
            chk($sformatf("u%0d_sum", i), sum_o[i], e.s);
            chk($sformatf("u%0d_cout", i), {63'd0, co_o[i]}, {63'd0, e.co});
            chk($sformatf("u%0d_ovf", i), {63'd0, ov_o[i]}, {63'd0, e.ov});
            if (lat_on) begin
              chk($sformatf("u%0d_latency", i), 64'(cyc - acc_cyc[i][rp[i] % 32]), 64'(stg(i)));
            end
            rp[i]++;
          end
        end
        if (iv_v[i] && ir_o[i]) begin
          if (i == 0 && have_lit) e = lit;
          else e = model(wid(i), a_v[i], b_v[i], cin_v[i], sub_v[i]);
          sb[i][wp[i] % 32]      = e;
          acc_cyc[i][wp[i] % 32] = cyc;
          wp[i]++;
          acc_cnt[i]++;
        end
      end
      prev_stall[i] = !rst && vo_o[i] && !or_v[i];
      prev_sum[i]   = sum_o[i];
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                       input logic [31:0] es, input logic eco, input logic eov);
    a_v[0] = {32'd0, a}; b_v[0] = {32'd0, b}; cin_v[0] = cin; sub_v[0] = sub; iv_v[0] = 1'b1;
    lit.s = {32'd0, es}; lit.co = eco; lit.ov = eov; have_lit = 1'b1;
    cycle();
    iv_v[0] = 1'b0; have_lit = 1'b0;
  endtask

  task automatic rand_ops(input int i);
    a_v[i]   = {$urandom(), $urandom()} & mask64(wid(i));
    b_v[i]   = {$urandom(), $urandom()} & mask64(wid(i));
    cin_v[i] = 1'($urandom_range(0, 1));
    sub_v[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic done;
    errors = 0; checks = 0; cyc = 0; lat_on = 1'b0; have_lit = 1'b0; lit = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = 64'd0; b_v[i] = 64'd0; cin_v[i] = 1'b0; sub_v[i] = 1'b0;
      iv_v[i] = 1'b0; or_v[i] = 1'b0; wp[i] = 0; rp[i] = 0; acc_cnt[i] = 0;
      prev_stall[i] = 1'b0; prev_sum[i] = 64'd0;
    end
    rst = 1'b1;
    apply();
    @(negedge clk);

    // Reset: transfer attempts are discarded; in_ready is 1 even with out_ready low.
    iv_v[0] = 1'b1; a_v[0] = 64'h1; b_v[0] = 64'h2;
    cycle();
    cycle();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d_rst_valid", i), {63'd0, vo_o[i]}, 64'd0);
      chk($sformatf("u%0d_rst_sum", i), sum_o[i], 64'd0);
      chk($sformatf("u%0d_rst_cout", i), {63'd0, co_o[i]}, 64'd0);
      chk($sformatf("u%0d_rst_ovf", i), {63'd0, ov_o[i]}, 64'd0);
      chk($sformatf("u%0d_rst_in_ready", i), {63'd0, ir_o[i]}, 64'd1);
      or_v[i] = 1'b1;
    end
    iv_v[0] = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("post_rst_no_output", {63'd0, vo_o[0]}, 64'd0);
    end

    // Directed streams with fixed expected results; latency checked on every pop.
    lat_on = 1'b1;
    send0(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0);
    send0(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    send0(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    send0(32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0);
    send0(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send0(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    send0(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    send0(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
    send0(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) cycle();
    lat_on = 1'b0;
    chk("directed_all_drained", 64'(wp[0] - rp[0]), 64'd0);
    chk("directed_count", 64'(acc_cnt[0]), 64'd9);

    // Backpressure: fill, stall 5 cycles with in_valid held, then drain.
    iv_v[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin rand_ops(0); cycle(); end
    or_v[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_ops(0);
      cycle();
      chk("stall_in_ready", {63'd0, ir_o[0]}, 64'd0);
      chk("stall_out_valid", {63'd0, vo_o[0]}, 64'd1);
    end
    or_v[0] = 1'b1; iv_v[0] = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    chk("backpressure_drained", 64'(wp[0] - rp[0]), 64'd0);

    // Reset mid-flight: three in flight are dropped, then one fresh transaction.
    iv_v[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin rand_ops(0); cycle(); end
    iv_v[0] = 1'b0;
    rst = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) rp[i] = wp[i];
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("midrst_no_output", {63'd0, vo_o[0]}, 64'd0);
    end
    lat_on = 1'b1;
    rand_ops(0); iv_v[0] = 1'b1;
    cycle();
    iv_v[0] = 1'b0;
    for (int c = 0; c < 6; c++) cycle();
    lat_on = 1'b0;
    chk("midrst_fresh_drained", 64'(wp[0] - rp[0]), 64'd0);

    // Random traffic on every parameter set, random valid and ready.
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      for (int i = 0; i < N; i++) begin
        rand_ops(i);
        iv_v[i] = (acc_cnt[i] < 1000) && ($urandom_range(0, 3) != 0);
        or_v[i] = ($urandom_range(0, 3) != 0);
      end
      cycle();
      done = 1'b1;
      for (int i = 0; i < N; i++) if (acc_cnt[i] < 1000) done = 1'b0;
    end
    for (int i = 0; i < N; i++) begin iv_v[i] = 1'b0; or_v[i] = 1'b1; end
    for (int c = 0; c < 20; c++) cycle();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d_random_accepted", i), 64'(acc_cnt[i]), 64'd1000);
      chk($sformatf("u%0d_random_drained", i), 64'(wp[i] - rp[i]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
